// File: rtl/chipper_pkg.sv
// chipper_pkg: flit field layout and idle/local route codes shared by
// the ingress stage and the downstream arbitration stage.
package chipper_pkg;

    localparam int FLIT_W   = 10;
    localparam int GOLD_BIT = 9;
    localparam int ROUTE_HI = 8;
    localparam int ROUTE_LO = 6;
    localparam int ID_HI    = 5;
    localparam int ID_LO    = 2;
    localparam int NSLOT    = 4;

    localparam logic [2:0] ROUTE_IDLE  = 3'b111;
    localparam logic [2:0] ROUTE_LOCAL = 3'b101;

    localparam logic [FLIT_W-1:0] IDLE_FLIT = 10'h1C0;

    typedef logic [FLIT_W-1:0] flit_t;

    function automatic logic [2:0] route_of(input flit_t f);
        return f[ROUTE_HI:ROUTE_LO];
    endfunction

    function automatic logic is_idle(input flit_t f);
        return route_of(f) == ROUTE_IDLE;
    endfunction

    function automatic logic is_local(input flit_t f);
        return route_of(f) == ROUTE_LOCAL;
    endfunction

endpackage

// File: rtl/chipper_ingress_golden_epoch.sv
// golden_epoch: epoch cycle counter and rotating golden packet ID.
// Ports: clk_i, rst_i (sync, active-high) in; gold_id_o out.
module golden_epoch #(
    parameter int EPOCH_LEN = 64,
    parameter int ID_W      = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [ID_W-1:0] gold_id_o
);

    localparam int CNT_W = (EPOCH_LEN > 2) ? $clog2(EPOCH_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EPOCH_LEN - 1);

    logic [CNT_W-1:0] epoch_cnt_q;
    logic [CNT_W-1:0] epoch_cnt_d;
    logic [ID_W-1:0]  gold_id_q;
    logic [ID_W-1:0]  gold_id_d;

    always_comb begin
        epoch_cnt_d = epoch_cnt_q + 1'b1;
        gold_id_d   = gold_id_q;
        if (epoch_cnt_q == CNT_MAX) begin
            epoch_cnt_d = '0;
            // natural wrap at 2^ID_W
            gold_id_d   = gold_id_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            epoch_cnt_q <= '0;
            gold_id_q   <= '0;
        end else begin
            epoch_cnt_q <= epoch_cnt_d;
            gold_id_q   <= gold_id_d;
        end
    end

    assign gold_id_o = gold_id_q;

endmodule

// File: rtl/chipper_ingress.sv
// chipper_ingress: registers four link flits, ejects one local flit,
// injects one local flit into a free slot, and re-marks golden bits.
// Ports: clk, rst (sync, active-high); in_n/e/s/w, inj_flit, inj_valid in;
// inj_ready (comb), eject_flit, eject_valid, out0..out3 (registered) out.
module chipper_ingress
    import chipper_pkg::*;
#(
    parameter int EPOCH_LEN = 64,
    parameter int ID_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_n,
    input  logic [FLIT_W-1:0] in_e,
    input  logic [FLIT_W-1:0] in_s,
    input  logic [FLIT_W-1:0] in_w,
    input  logic [FLIT_W-1:0] inj_flit,
    input  logic              inj_valid,
    output logic              inj_ready,
    output logic [FLIT_W-1:0] eject_flit,
    output logic              eject_valid,
    output logic [FLIT_W-1:0] out0,
    output logic [FLIT_W-1:0] out1,
    output logic [FLIT_W-1:0] out2,
    output logic [FLIT_W-1:0] out3
);

    logic [ID_W-1:0] gold_id;

    golden_epoch #(
        .EPOCH_LEN (EPOCH_LEN),
        .ID_W      (ID_W)
    ) u_epoch (
        .clk_i     (clk),
        .rst_i     (rst),
        .gold_id_o (gold_id)
    );

    flit_t in_slot [NSLOT];
    flit_t slot    [NSLOT];
    flit_t slot_d  [NSLOT];
    flit_t out_q   [NSLOT];

    flit_t eject_flit_q;
    flit_t eject_flit_d;
    logic  eject_valid_q;
    logic  eject_valid_d;
    logic  any_free;
    logic  inj_ready_c;
    logic  inj_done;

    always_comb begin
        in_slot[0] = in_n;
        in_slot[1] = in_e;
        in_slot[2] = in_s;
        in_slot[3] = in_w;

        slot          = in_slot;
        eject_valid_d = 1'b0;
        eject_flit_d  = eject_flit_q;

        // first local flit in N,E,S,W order leaves; later ones are deflected
        for (int i = 0; i < NSLOT; i++) begin
            if (!eject_valid_d && is_local(in_slot[i])) begin
                eject_valid_d = 1'b1;
                eject_flit_d  = in_slot[i];
                slot[i]       = IDLE_FLIT;
            end
        end

        any_free = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (is_idle(slot[i])) begin
                any_free = 1'b1;
            end
        end

        inj_ready_c = any_free && !rst;

        // an idle-coded injection lands as idle, i.e. it is discarded
        inj_done = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (inj_valid && inj_ready_c && !inj_done && is_idle(slot[i])) begin
                inj_done = 1'b1;
                slot[i]  = inj_flit;
            end
        end

        for (int i = 0; i < NSLOT; i++) begin
            slot_d[i] = slot[i];
            if (is_idle(slot[i])) begin
                slot_d[i] = IDLE_FLIT;
            end else begin
                slot_d[i][GOLD_BIT] =
                    (ID_W'(slot[i][ID_HI:ID_LO]) == gold_id);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                out_q[i] <= IDLE_FLIT;
            end
            eject_flit_q  <= '0;
            eject_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                out_q[i] <= slot_d[i];
            end
            eject_flit_q  <= eject_flit_d;
            eject_valid_q <= eject_valid_d;
        end
    end

    assign inj_ready   = inj_ready_c;
    assign eject_flit  = eject_flit_q;
    assign eject_valid = eject_valid_q;
    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];

endmodule

// File: doc/chipper_ingress.md
# chipper_ingress

Input pipeline stage of the bufferless deflection router. It registers the four neighbour-link flits and removes at most one locally destined flit per cycle. It injects at most one local flit into a free slot and recomputes each flit's golden bit from a rotating epoch ID. Its four registered outputs feed the two-input arbitration/permutation network directly downstream.

## Interface
Flit format, 10 bits:
- [9] golden
- [8:6] route code: 3'b111 idle, 3'b101 local/eject, other codes are output directions passed through untouched
- [5:2] packet ID
- [1:0] payload

Parameters:
- EPOCH_LEN, 64, cycles per golden epoch (≥2)
- ID_W, 4, packet-ID width; golden ID wraps modulo 2^ID_W

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_n, in_e, in_s, in_w  in  10 each  link flits, sampled every cycle, no handshake
- inj_flit  in  10  local injection flit
- inj_valid  in  1  injection request
- inj_ready  out  1  combinational; high when a slot is free this cycle
- eject_flit  out  10  registered ejected flit
- eject_valid  out  1  registered, one-cycle pulse per ejection
- out0..out3  out  10 each  registered slots (N,E,S,W order) to the permutation stage

## Operation
- Idle test: route code 3'b111. Other bits of an idle flit are ignored. Idle slots are driven out normalised as 10'h1C0.
- Eject:
  - Scan slots N,E,S,W and take the first with route 3'b101.
  - That flit goes to eject_flit with eject_valid=1, and its slot becomes idle.
  - Further local flits in the same cycle pass through unchanged and are deflected by downstream logic.
- Inject:
  - inj_ready = at least one slot idle after ejection. A slot freed by this cycle's ejection counts.
  - When inj_valid && inj_ready, inj_flit fills the lowest-index idle slot, in N,E,S,W order.
  - When inj_valid && !inj_ready, nothing is consumed; the source holds inj_flit.
  - An injected flit whose route is 3'b111 is accepted and discarded.
- Golden:
  - For every non-idle output flit, bit 9 = (flit[5:2] == gold_id), using the current-cycle gold_id.
  - The incoming bit 9 is always overwritten. The ejected flit keeps bit 9 as received.
- Epoch:
  - epoch_cnt counts 0..EPOCH_LEN-1.
  - At EPOCH_LEN-1 it goes to 0 and gold_id increments, wrapping 2^ID_W-1 → 0.

## Timing
- Latency is one cycle from in_*/inj_flit to out*/eject_*. There is no bubble; the stage accepts a full set every cycle.
- Reset (sync, active-high):
  - out0..out3 = 10'h1C0, eject_flit = 10'h000, eject_valid = 0.
  - epoch_cnt = 0, gold_id = 0.
  - inj_ready is low while rst is high.
- Reset mid-operation: inputs sampled while rst is high are dropped. There is no partial injection and no ejection pulse.
- All four slots full and non-local: inj_ready = 0.
- Same-cycle eject and inject into the freed slot is legal and required.
- Epoch rollover cycle: flits in that cycle use the old gold_id. The new ID applies from the next cycle.

## Structure
- Package chipper_pkg holds:
  - FLIT_W = 10
  - field positions GOLD_BIT, ROUTE_HI/LO, ID_HI/LO
  - ROUTE_IDLE = 3'b111, ROUTE_LOCAL = 3'b101
  - IDLE_FLIT = 10'h1C0
- The downstream arbitration stage imports chipper_pkg for the same fields.
- Sub-module golden_epoch contains epoch_cnt and gold_id and outputs gold_id. The rest is a flat combinational eject/inject selection plus one register bank.

## Test plan
- Reset then idle inputs:
  - out* = 10'h1C0, eject_valid = 0, inj_ready = 1.
  - After exactly 64 cycles gold_id = 1.
- Locals on E and W plus a direction flit on N:
  - in_e = 10'h144 and in_w = 10'h148 (route 101, IDs 1 and 2); in_n = 10'h00C (route 000, ID 3).
  - Next cycle: eject_flit = 10'h144, eject_valid = 1, out1 = 10'h1C0, out3 = 10'h148 (passed through), out0 = 10'h00C.
- All four inputs route 3'b010 with inj_valid = 1:
  - inj_ready = 0, no slot changes, injection held.
  - When in_s goes idle: injection lands in out2 on the next cycle.
- Eject on N, all other slots full, inj_flit = 10'h0A0:
  - inj_ready = 1.
  - Next cycle: out0 = 10'h0A0, eject_valid = 1.
- Golden marking, with gold_id = 0:
  - in_n = 10'h200 (golden bit set, ID 0) → out0 = 10'h200.
  - in_e = 10'h204 (golden bit set, ID 1) → out1 = 10'h004.
  - Across the rollover to gold_id = 1, ID 1 flits gain bit 9 starting the cycle after the wrap.
- Assert rst mid-traffic for one cycle:
  - Next cycle all out* = 10'h1C0 and eject_valid = 0.
  - epoch_cnt restarts, so the first rollover comes 64 cycles after rst drops.
